sram_write_monitor: RTL and testbench

Synthesizable, parametrised successor to the bench-side SRAM write checker. It snoops the SRAM write bus between the decoder core and the SRAM controller and tracks a configurable target region. Per run it counts in-region writes, out-of-region writes and repeated writes, counts never-written locations, and accumulates an order-independent data signature. Results are exposed to the top level (seven-segment/UART debug) so on-board runs can be checked without a simulator.

---
 rtl/sram_write_monitor.sv | 259 +++++++++++++++++++++++++
 tb/tb_sram_write_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_write_monitor.sv
// sram_write_monitor
// Snoops the SRAM write bus and tracks one target region per run: counts
// in-region, out-of-region and repeated writes, accumulates an order-free
// data signature and, once the run is finished, counts the locations that
// were never written. A 1-bit-per-word bitmap in block RAM remembers which
// offsets have been written during the current run.
//
// Control interface: Start and Finish are single-cycle pulses sampled on the
// rising edge of Clock. Start is taken in ARMED, DONE and IDLE and ignored in
// CLEAR and SCAN. Finish is taken only in ARMED (Start wins if both are
// high). There is no back-pressure: a write is any cycle with SRAM_we_n low.
// State is exposed on the State output (0 CLEAR, 1 ARMED, 2 SCAN, 3 DONE,
// 4 IDLE).
module sram_write_monitor #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int REGION_BASE = 0,
    parameter int REGION_SIZE = 76800,
    parameter int CNT_W       = 20,
    parameter int SIG_W       = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Finish,
    input  logic              SRAM_we_n,
    input  logic [ADDR_W-1:0] SRAM_address,
    input  logic [DATA_W-1:0] SRAM_write_data,
    output logic              Busy,
    output logic              Armed,
    output logic              Done,
    output logic [CNT_W-1:0]  Write_count,
    output logic [CNT_W-1:0]  Out_of_region_count,
    output logic [CNT_W-1:0]  Multi_write_count,
    output logic [CNT_W-1:0]  Unwritten_count,
    output logic [SIG_W-1:0]  Signature,
    output logic [2:0]        State
);

    // OFF_W addresses the bitmap; PTR_W can also hold REGION_SIZE itself,
    // which the scan pointer reaches once every offset has been read.
    localparam int OFF_W = $clog2(REGION_SIZE);
    localparam int PTR_W = $clog2(REGION_SIZE + 1);
    localparam logic [ADDR_W:0]   REGION_LO = (ADDR_W+1)'(REGION_BASE);
    localparam logic [ADDR_W:0]   REGION_HI = (ADDR_W+1)'(REGION_BASE + REGION_SIZE);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(REGION_SIZE - 1);
    localparam logic [PTR_W-1:0]  END_PTR   = PTR_W'(REGION_SIZE);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_ARMED = 3'd1,
        S_SCAN  = 3'd2,
        S_DONE  = 3'd3,
        S_IDLE  = 3'd4
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic               draining;
    logic               scan_rv;

    // Stage-1 registers: the write sampled in the previous cycle.
    logic               p1_valid;
    logic               p1_inreg;
    logic [OFF_W-1:0]   p1_off;
    logic [ADDR_W-1:0]  p1_addr;
    logic [DATA_W-1:0]  p1_data;

    // Offset written to the bitmap by stage 1 on the previous edge; the RAM
    // read issued on that same edge returned the old bit, so it is forwarded.
    logic               fwd_valid;
    logic [OFF_W-1:0]   fwd_off;

    logic               bitmap [REGION_SIZE];
    logic               rd_bit;

    logic               ram_we;
    logic [OFF_W-1:0]   ram_wa;
    logic               ram_wd;
    logic               ram_re;
    logic [OFF_W-1:0]   ram_ra;

    logic [ADDR_W:0]    addr_x;
    logic               in_region;
    logic [OFF_W-1:0]   in_off;
    logic               sample;
    logic               restart;
    logic               repeat_hit;
    logic [SIG_W-1:0]   sig_term;

    assign State = state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Stage-0 decode of the snooped bus and the restart / repeat conditions.
    always_comb begin
        addr_x     = {1'b0, SRAM_address};
        in_region  = (addr_x >= REGION_LO) && (addr_x < REGION_HI);
        in_off     = OFF_W'(SRAM_address - ADDR_W'(REGION_BASE));
        sample     = (state == S_ARMED) && !draining && !SRAM_we_n;
        restart    = Start && ((state == S_ARMED) || (state == S_DONE) || (state == S_IDLE));
        repeat_hit = rd_bit || (fwd_valid && (fwd_off == p1_off));
        sig_term   = SIG_W'({p1_addr, p1_data});
    end

    // Bitmap port arbitration: sweep writes in CLEAR, lookup and mark in
    // ARMED, sequential reads in SCAN.
    always_comb begin
        ram_we = 1'b0;
        ram_wa = '0;
        ram_wd = 1'b0;
        ram_re = 1'b0;
        ram_ra = '0;
        case (state)
            S_CLEAR: begin
                ram_we = Busy;
                ram_wa = OFF_W'(ptr);
            end
            S_ARMED: begin
                ram_we = p1_valid && p1_inreg;
                ram_wa = p1_off;
                ram_wd = 1'b1;
                ram_re = sample && in_region;
                ram_ra = in_off;
            end
            S_SCAN: begin
                ram_re = (ptr < END_PTR);
                ram_ra = OFF_W'(ptr);
            end
            default: begin
            end
        endcase
    end

    // Bitmap block RAM with a registered read; deliberately not reset.
    always_ff @(posedge Clock) begin
        if (ram_we)
            bitmap[ram_wa] <= ram_wd;
        if (ram_re)
            rd_bit <= bitmap[ram_ra];
    end

    // Run controller, write pipeline and result counters.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state               <= S_CLEAR;
            ptr                 <= '0;
            draining            <= 1'b0;
            scan_rv             <= 1'b0;
            p1_valid            <= 1'b0;
            p1_inreg            <= 1'b0;
            p1_off              <= '0;
            p1_addr             <= '0;
            p1_data             <= '0;
            fwd_valid           <= 1'b0;
            fwd_off             <= '0;
            Busy                <= 1'b0;
            Armed               <= 1'b0;
            Done                <= 1'b0;
            Write_count         <= '0;
            Out_of_region_count <= '0;
            Multi_write_count   <= '0;
            Unwritten_count     <= '0;
            Signature           <= '0;
        end else begin
            Done      <= 1'b0;
            fwd_valid <= 1'b0;
            if (restart) begin
                state               <= S_CLEAR;
                ptr                 <= '0;
                draining            <= 1'b0;
                scan_rv             <= 1'b0;
                p1_valid            <= 1'b0;
                Busy                <= 1'b1;
                Armed               <= 1'b0;
                Write_count         <= '0;
                Out_of_region_count <= '0;
                Multi_write_count   <= '0;
                Unwritten_count     <= '0;
                Signature           <= '0;
            end else begin
                case (state)
                    S_CLEAR: begin
                        // Busy low only on the first cycle after reset: raise
                        // it first so the sweep itself is fully visible.
                        if (!Busy) begin
                            Busy <= 1'b1;
                        end else if (ptr == LAST_PTR) begin
                            state <= S_ARMED;
                            ptr   <= '0;
                            Busy  <= 1'b0;
                            Armed <= 1'b1;
                        end else begin
                            ptr <= ptr + PTR_W'(1);
                        end
                    end
                    S_ARMED: begin
                        if (p1_valid) begin
                            if (p1_inreg) begin
                                Write_count <= sat_inc(Write_count);
                                Signature   <= Signature + sig_term;
                                if (repeat_hit)
                                    Multi_write_count <= sat_inc(Multi_write_count);
                                fwd_valid <= 1'b1;
                                fwd_off   <= p1_off;
                            end else begin
                                Out_of_region_count <= sat_inc(Out_of_region_count);
                            end
                        end
                        p1_valid <= sample;
                        p1_inreg <= in_region;
                        p1_off   <= in_off;
                        p1_addr  <= SRAM_address;
                        p1_data  <= SRAM_write_data;
                        if (draining) begin
                            // The last sampled write completes on this edge.
                            state    <= S_SCAN;
                            draining <= 1'b0;
                            p1_valid <= 1'b0;
                            ptr      <= '0;
                            scan_rv  <= 1'b0;
                            Armed    <= 1'b0;
                            Busy     <= 1'b1;
                        end else if (Finish) begin
                            draining <= 1'b1;
                        end
                    end
                    S_SCAN: begin
                        if (ptr < END_PTR) begin
                            ptr     <= ptr + PTR_W'(1);
                            scan_rv <= 1'b1;
                        end else begin
                            scan_rv <= 1'b0;
                        end
                        if (scan_rv && !rd_bit)
                            Unwritten_count <= sat_inc(Unwritten_count);
                        if ((ptr == END_PTR) && scan_rv) begin
                            state <= S_DONE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    S_IDLE: begin
                    end
                    default: begin
                        state <= S_CLEAR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_write_monitor.sv
// Directed bench for sram_write_monitor with a 16-word region at base 16.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_sram_write_monitor;

    localparam int ADDR_W      = 18;
    localparam int DATA_W      = 16;
    localparam int REGION_BASE = 16;
    localparam int REGION_SIZE = 16;
    localparam int CNT_W       = 20;
    localparam int SIG_W       = 32;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              Start;
    logic              Finish;
    logic              SRAM_we_n;
    logic [ADDR_W-1:0] SRAM_address;
    logic [DATA_W-1:0] SRAM_write_data;
    logic              Busy;
    logic              Armed;
    logic              Done;
    logic [CNT_W-1:0]  Write_count;
    logic [CNT_W-1:0]  Out_of_region_count;
    logic [CNT_W-1:0]  Multi_write_count;
    logic [CNT_W-1:0]  Unwritten_count;
    logic [SIG_W-1:0]  Signature;
    logic [2:0]        state_dbg;

    int checks = 0;
    int errors = 0;

    sram_write_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REGION_BASE(REGION_BASE),
        .REGION_SIZE(REGION_SIZE), .CNT_W(CNT_W), .SIG_W(SIG_W)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Finish(Finish),
        .SRAM_we_n(SRAM_we_n), .SRAM_address(SRAM_address),
        .SRAM_write_data(SRAM_write_data), .Busy(Busy), .Armed(Armed),
        .Done(Done), .Write_count(Write_count),
        .Out_of_region_count(Out_of_region_count),
        .Multi_write_count(Multi_write_count),
        .Unwritten_count(Unwritten_count), .Signature(Signature),
        .State(state_dbg)
    );

    // Clock/reset block: 50 MHz clock.
    always #10 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_counts"}, {4'h0, Write_count, Out_of_region_count, Multi_write_count}, 64'd0);
        check({tag, "_unw_sig"}, {12'h0, Unwritten_count, Signature}, 64'd0);
    endtask

    // Count Busy cycles until Armed rises; Start is pulsed on cycle start_at.
    task automatic wait_armed(input int start_at, output int busy_n);
        busy_n = 0;
        for (int i = 0; i < 60; i++) begin
            Start = (i == start_at);
            tick();
            if (Armed) break;
            if (Busy) busy_n++;
        end
        Start = 1'b0;
    endtask

    task automatic start_run(input string tag);
        int n;
        int m;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        n = Busy ? 1 : 0;
        wait_armed(-1, m);
        check({tag, "_busy_cycles"}, 64'(n + m), 64'd16);
        check({tag, "_armed"}, 64'(Armed), 64'd1);
        check_cleared(tag);
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        SRAM_we_n       = 1'b0;
        SRAM_address    = a;
        SRAM_write_data = d;
        tick();
        SRAM_we_n = 1'b1;
    endtask

    task automatic finish_run(input string tag, input bit with_write,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit seen;
        Finish = 1'b1;
        if (with_write) begin
            SRAM_we_n       = 1'b0;
            SRAM_address    = a;
            SRAM_write_data = d;
        end
        tick();
        Finish    = 1'b0;
        SRAM_we_n = 1'b1;
        tick();
        check({tag, "_scan_entry"}, 64'(Busy), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (Done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        tick();
        check({tag, "_done_pulse_len"}, 64'(Done), 64'd0);
    endtask

    initial begin
        int n;
        Reset = 1'b1; Start = 1'b0; Finish = 1'b0;
        SRAM_we_n = 1'b1; SRAM_address = '0; SRAM_write_data = '0;
        repeat (3) tick();
        check("reset_flags", {61'h0, Busy, Armed, Done}, 64'd0);
        check_cleared("reset");

        Reset = 1'b0;
        wait_armed(-1, n);
        check("init_busy_cycles", 64'(n), 64'd16);
        check("init_armed", 64'(Armed), 64'd1);
        check_cleared("init");

        // Every offset once, data = address.
        for (int a = 16; a < 32; a++) write_word(ADDR_W'(a), DATA_W'(a));
        finish_run("seq", 1'b0, '0, '0);
        check("seq_wc", 64'(Write_count), 64'd16);
        check("seq_multi", 64'(Multi_write_count), 64'd0);
        check("seq_oor", 64'(Out_of_region_count), 64'd0);
        check("seq_unw", 64'(Unwritten_count), 64'd0);
        check("seq_sig", 64'(Signature), 64'd24641912);   // 376 * 65537
        check("seq_state_idle", 64'(state_dbg), 64'd4);

        // Repeats to offset 4: back-to-back (forwarded) and 5 cycles later.
        start_run("fwd");
        write_word(18'd20, 16'd1);
        check("fwd_latency0", 64'(Write_count), 64'd0);
        write_word(18'd20, 16'd2);
        check("fwd_latency1", 64'(Write_count), 64'd1);
        repeat (4) tick();
        write_word(18'd20, 16'd3);
        repeat (2) tick();
        check("fwd_wc", 64'(Write_count), 64'd3);
        check("fwd_multi", 64'(Multi_write_count), 64'd2);
        check("fwd_sig", 64'(Signature), 64'd3932166);    // 3*(20<<16) + 6
        finish_run("fwd", 1'b0, '0, '0);
        check("fwd_unw", 64'(Unwritten_count), 64'd15);

        // Out-of-region writes just below, just above and at the top address.
        start_run("oor");
        write_word(18'd15, 16'h1234);
        write_word(18'd32, 16'h5678);
        write_word(18'h3FFFF, 16'hFFFF);
        repeat (2) tick();
        check("oor_count", 64'(Out_of_region_count), 64'd3);
        check("oor_wc", 64'(Write_count), 64'd0);
        finish_run("oor", 1'b0, '0, '0);
        check("oor_unw", 64'(Unwritten_count), 64'd16);
        check("oor_sig", 64'(Signature), 64'd0);
        // Writes in IDLE must not be counted; results hold.
        write_word(18'd20, 16'd7);
        repeat (3) tick();
        check("idle_wc_hold", 64'(Write_count), 64'd0);
        check("idle_oor_hold", 64'(Out_of_region_count), 64'd3);

        // Offsets 0..9, last write in the Finish cycle.
        start_run("fin");
        for (int a = 16; a < 25; a++) write_word(ADDR_W'(a), 16'd0);
        finish_run("fin", 1'b1, 18'd25, 16'd0);
        check("fin_wc", 64'(Write_count), 64'd10);
        check("fin_unw", 64'(Unwritten_count), 64'd6);
        check("fin_sig", 64'(Signature), 64'd13434880);  // 205 << 16
        check("fin_multi", 64'(Multi_write_count), 64'd0);

        // Start and Finish together in ARMED: restart wins.
        start_run("both");
        write_word(18'd16, 16'd9);
        Start = 1'b1; Finish = 1'b1;
        tick();
        Start = 1'b0; Finish = 1'b0;
        check("both_busy", 64'(Busy), 64'd1);
        check("both_armed", 64'(Armed), 64'd0);
        check("both_wc", 64'(Write_count), 64'd0);
        wait_armed(-1, n);
        check("both_busy_cycles", 64'(n + 1), 64'd16);

        // Reset in the middle of SCAN, then Start during the new CLEAR.
        write_word(18'd17, 16'd1);
        Finish = 1'b1;
        tick();
        Finish = 1'b0;
        tick();
        check("rst_in_scan", 64'(Busy), 64'd1);
        repeat (3) tick();
        #2 Reset = 1'b1;
        #1;
        check("rst_async_flags", {61'h0, Busy, Armed, Done}, 64'd0);
        check_cleared("rst_async");
        tick();
        check("rst_edge_flags", {61'h0, Busy, Armed, Done}, 64'd0);
        Reset = 1'b0;
        wait_armed(5, n);
        check("rst_busy_cycles", 64'(n), 64'd16);
        check("rst_armed", 64'(Armed), 64'd1);
        check_cleared("rst_rearm");
        finish_run("rst", 1'b0, '0, '0);
        check("rst_unw", 64'(Unwritten_count), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
